// File: rtl/bitvec_frame_pkg.sv
// Shared types and byte codes for the bit-vector ASCII framer.
package bitvec_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BITS = 2'd1,
    TERM = 2'd2
  } state_t;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_ONE  = 8'h31;
  localparam logic [7:0] CHAR_TERM = 8'h2A;

  function automatic logic [7:0] bit_char(input logic b);
    return b ? CHAR_ONE : CHAR_ZERO;
  endfunction

endpackage

// File: rtl/vec_settle_det.sv
// Registers the incoming vector and reports when it has held unchanged
// for SETTLE_CYCLES consecutive samples.
module vec_settle_det
  import bitvec_frame_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic [WIDTH-1:0] vec_i,
  output logic [WIDTH-1:0] vec_q_o,
  output logic             settled_o
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);

  logic [WIDTH-1:0] vec_q;
  logic [CNT_W-1:0] stable_cnt_q;
  logic [CNT_W-1:0] stable_cnt_d;

  // Any difference from the previous sample restarts the count; otherwise saturate.
  always_comb begin
    stable_cnt_d = stable_cnt_q;
    if (vec_i != vec_q) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q != CNT_MAX) begin
      stable_cnt_d = stable_cnt_q + CNT_W'(1);
    end else begin
      stable_cnt_d = stable_cnt_q;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      vec_q        <= '0;
      stable_cnt_q <= '0;
    end else begin
      vec_q        <= vec_i;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  assign vec_q_o   = vec_q;
  assign settled_o = (stable_cnt_q == CNT_MAX);

endmodule

// File: rtl/bitvec_frame_tx.sv
// Streams a settled snapshot of vec_in as ASCII '0'/'1' bytes, LSB first,
// followed by '*', over a valid/ready byte interface.
module bitvec_frame_tx
  import bitvec_frame_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int SETTLE_CYCLES = 4,
  parameter int ON_CHANGE     = 0
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic [WIDTH-1:0] vec_in,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             frame_busy,
  output logic [15:0]      frames_sent
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] snap_q;
  logic [WIDTH-1:0] last_sent_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic [15:0]      frames_sent_q;

  logic [WIDTH-1:0] vec_q_s;
  logic             settled_s;
  logic             launch_s;
  logic             xfer_s;

  vec_settle_det #(
    .WIDTH        (WIDTH),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk_48mhz(clk_48mhz),
    .reset    (reset),
    .vec_i    (vec_in),
    .vec_q_o  (vec_q_s),
    .settled_o(settled_s)
  );

  assign launch_s = settled_s && ((ON_CHANGE == 0) || (vec_q_s != last_sent_q));
  assign xfer_s   = tx_valid_q && tx_ready;

  // Outputs are loaded together with the state so the first byte appears on the launch edge.
  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      snap_q        <= '0;
      last_sent_q   <= '0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      frames_sent_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch_s) begin
            snap_q     <= vec_q_s;
            idx_q      <= '0;
            tx_data_q  <= bit_char(vec_q_s[0]);
            tx_valid_q <= 1'b1;
            state_q    <= BITS;
          end
        end
        BITS: begin
          if (xfer_s) begin
            if (idx_q == IDX_LAST) begin
              tx_data_q <= CHAR_TERM;
              state_q   <= TERM;
            end else begin
              idx_q     <= idx_q + IDX_W'(1);
              tx_data_q <= bit_char(snap_q[idx_q + IDX_W'(1)]);
            end
          end
        end
        TERM: begin
          if (xfer_s) begin
            last_sent_q   <= snap_q;
            frames_sent_q <= frames_sent_q + 16'd1;
            tx_valid_q    <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign frame_busy  = (state_q != IDLE);
  assign frames_sent = frames_sent_q;

endmodule
